// File: rtl/wb_reg_pkg.sv
// Shared definitions for the Wishbone register slave: register map, default ID,
// FSM state encoding and the byte-lane merge helper.
package wb_reg_pkg;

  localparam logic [2:0] REG_ID       = 3'd0;
  localparam logic [2:0] REG_SCRATCH0 = 3'd1;
  localparam logic [2:0] REG_SCRATCH1 = 3'd2;
  localparam logic [2:0] REG_LEDS     = 3'd3;
  localparam logic [2:0] REG_COUNTER  = 3'd4;
  localparam logic [2:0] REG_BUTTON   = 3'd5;
  localparam logic [2:0] REG_ERRCNT   = 3'd6;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5742_0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    merged = cur;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous inputs into the clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wb_reg_slave.sv
// Pipelined Wishbone B4 slave with an 8-entry register bank; one ack or err per
// accepted request, optional wait states, state exposed on o_dbg_state.
module wb_reg_slave
  import wb_reg_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_data,
  input  logic        i_button,
  output logic [7:0]  o_leds,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a request is accepted on a rising edge where cyc & stb & !stall;
  // each accepted request gets exactly one single-cycle ack or err unless cyc
  // drops (or reset hits) before the response is issued.

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  wb_state_e   state, state_next;
  logic [3:0]  wait_cnt, wait_cnt_next;
  logic        accept;
  logic        unmapped;
  logic        resp_err;
  logic [31:0] cap_data;
  logic [31:0] rd_mux;
  logic [2:0]  idx;

  logic [31:0] scratch0, scratch1, counter;
  logic [7:0]  leds, errcnt;
  logic        button_sync;

  sync_2ff #(.WIDTH(1)) u_button_sync (
    .clk   (i_clk),
    .reset (i_reset),
    .d     (i_button),
    .q     (button_sync)
  );

  assign idx      = i_wb_addr[2:0];
  assign accept   = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign unmapped = (|i_wb_addr[29:3]) | (idx == 3'd7);

  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_ID:       rd_mux = ID_VALUE;
      REG_SCRATCH0: rd_mux = scratch0;
      REG_SCRATCH1: rd_mux = scratch1;
      REG_LEDS:     rd_mux = {24'd0, leds};
      REG_COUNTER:  rd_mux = counter;
      REG_BUTTON:   rd_mux = {31'd0, button_sync};
      REG_ERRCNT:   rd_mux = {24'd0, errcnt};
      default:      rd_mux = '0;
    endcase
    if (unmapped || i_wb_we) rd_mux = '0;
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          wait_cnt_next = WS;
          state_next    = (WS == 4'd0) ? RESP : WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (!i_wb_cyc) begin
          state_next = IDLE;
        end else if (wait_cnt <= 4'd1) begin
          state_next = RESP;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      resp_err  <= 1'b0;
      cap_data  <= '0;
      o_wb_data <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        resp_err <= unmapped;
        cap_data <= rd_mux;
      end
      // With no wait states the response starts on the acceptance edge itself.
      if (state_next == RESP) o_wb_data <= accept ? rd_mux : cap_data;
    end
  end

  assign o_wb_stall  = (state == WAIT);
  assign o_wb_ack    = (state == RESP) & ~resp_err;
  assign o_wb_err    = (state == RESP) & resp_err;
  assign o_dbg_state = state;
  assign o_leds      = leds;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      scratch0 <= '0;
      scratch1 <= '0;
      leds     <= '0;
      counter  <= '0;
      errcnt   <= '0;
    end else begin
      counter <= counter + 32'd1;
      if (o_wb_err && errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
      if (accept && i_wb_we && !unmapped) begin
        case (idx)
          REG_SCRATCH0: scratch0 <= byte_merge(scratch0, i_wb_data, i_wb_sel);
          REG_SCRATCH1: scratch1 <= byte_merge(scratch1, i_wb_data, i_wb_sel);
          REG_LEDS:     if (i_wb_sel[0]) leds <= i_wb_data[7:0];
          // A clear beats a same-cycle increment; sel=0 writes leave it alone.
          REG_ERRCNT:   if (|i_wb_sel) errcnt <= '0;
          default: ;
        endcase
      end
    end
  end

endmodule
